// File: rtl/mult_pkg.sv
// Shared definitions for the multdiv multiplier: FSM state codes, Booth
// partial-product classes and helpers that size the iteration counter.
package mult_pkg;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_RUN  = 2'd1;
  localparam logic [1:0] MS_DONE = 2'd2;

  localparam logic [2:0] BOOTH_ZERO = 3'd0;
  localparam logic [2:0] BOOTH_P1   = 3'd1;
  localparam logic [2:0] BOOTH_P2   = 3'd2;
  localparam logic [2:0] BOOTH_M2   = 3'd3;
  localparam logic [2:0] BOOTH_M1   = 3'd4;

  // Number of radix-4 iterations for a given operand width
  function automatic int mult_iter(input int width);
    return width / 2;
  endfunction

  // Counter width able to hold 0 .. ITER-1 (at least one bit)
  function automatic int mult_cnt_w(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

  // Map the overlapping three-bit Booth window to a partial-product class
  function automatic logic [2:0] booth_decode(input logic [2:0] booth);
    logic [2:0] cls;
    case (booth)
      3'b001, 3'b010: cls = BOOTH_P1;
      3'b011:         cls = BOOTH_P2;
      3'b100:         cls = BOOTH_M2;
      3'b101, 3'b110: cls = BOOTH_M1;
      default:        cls = BOOTH_ZERO;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Combinational radix-4 Booth partial-product selector. The multiplicand
// arrives already sign-extended to WIDTH+2 bits so that +/-2A never overflows.
module booth_pp_select
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       booth,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+1:0] pp
);

  logic signed [WIDTH+1:0] mcand_s;
  logic signed [WIDTH+1:0] dbl_s;

  assign mcand_s = $signed(mcand);
  assign dbl_s   = mcand_s <<< 1;

  // Pick 0, +A, +2A, -2A or -A from the Booth window
  always_comb begin
    pp = '0;
    case (booth_decode(booth))
      BOOTH_P1: pp = mcand_s;
      BOOTH_P2: pp = dbl_s;
      BOOTH_M2: pp = -dbl_s;
      BOOTH_M1: pp = -mcand_s;
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential radix-4 Booth multiplier controller (WIDTH/2 iterations, one
// per cycle). Optional build macro MULT_ABORT_EN adds ctrl_abort, which
// cancels an operation in flight without raising data_resultRDY.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
`ifdef MULT_ABORT_EN
  input  logic             ctrl_abort,
`endif
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int ITER  = mult_iter(WIDTH);
  localparam int CNT_W = mult_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam int ACC_W = 2 * WIDTH + 3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] mcand_q, mcand_d;
  logic [WIDTH+1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             g_q, g_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             abort_w;
  logic             load_w;
  logic             step_w;
  logic             last_w;
  logic [WIDTH+1:0] pp_w;
  logic [WIDTH+1:0] sum_w;
  logic [ACC_W-1:0] shifted_w;
  logic [WIDTH+1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             g_n;
  logic [WIDTH+2:0] top_n;

`ifdef MULT_ABORT_EN
  assign abort_w = ctrl_abort;
`else
  assign abort_w = 1'b0;
`endif

  // A start is only accepted when no operation is in flight
  assign load_w = ctrl_MULT && ((state_q == MS_IDLE) || (state_q == MS_DONE));
  assign step_w = (state_q == MS_RUN) && !abort_w;
  assign last_w = step_w && (cnt_q == CNT_LAST);

  booth_pp_select #(
    .WIDTH(WIDTH)
  ) u_pp (
    .booth(({lo_q[1:0], g_q})),
    .mcand(mcand_q),
    .pp   (pp_w)
  );

  // One Booth step: add the partial product into hi, then shift {hi,lo,g} right by two
  assign sum_w     = hi_q + pp_w;
  assign shifted_w = $unsigned($signed({sum_w, lo_q, g_q}) >>> 2);
  assign hi_n      = shifted_w[ACC_W-1:WIDTH+1];
  assign lo_n      = shifted_w[WIDTH:1];
  assign g_n       = shifted_w[0];
  assign top_n     = {hi_n, lo_n[WIDTH-1]};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MS_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort only matters while iterating, so start wins in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (ctrl_MULT) state_d = MS_RUN;
      MS_RUN: begin
        if (abort_w)     state_d = MS_IDLE;
        else if (last_w) state_d = MS_DONE;
      end
      MS_DONE: state_d = ctrl_MULT ? MS_RUN : MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    busy           = (state_q == MS_RUN);
    data_resultRDY = (state_q == MS_DONE);
  end

  // Datapath next values: load on start, step while running, capture on the last step
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    g_d      = g_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (load_w) begin
      cnt_d   = '0;
      mcand_d = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      hi_d    = '0;
      lo_d    = data_operandB;
      g_d     = 1'b0;
    end else if (step_w) begin
      cnt_d = cnt_q + CNT_W'(1);
      hi_d  = hi_n;
      lo_d  = lo_n;
      g_d   = g_n;
      if (last_w) begin
        result_d = lo_n;
        exc_d    = !((&top_n) || !(|top_n));
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      g_q      <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      g_q      <= g_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule
